mar_mdr_mem_if: RTL and testbench
=================================

Name: mar_mdr_mem_if

Overview:
- Memory-interface stage of the LC-3 datapath. It is the consumer of BUS for address/data loads and the producer of MDR_OUT, which feeds the bus driver.
- Holds the MAR and MDR registers.
- Runs read/write transactions against an external memory over a req/ack handshake.
- Returns the LC-3 ready signal R to the control FSM, with a timeout so a missing ack cannot hang the machine.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in READ/WRITE without MEM_ACK before abort; must be >= 1.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- i_Clk  input  1  system clock; all state updates on rising edge.
- i_Rst  input  1  reset, synchronous, active-high.
- BUS  input  16  datapath bus.
- LD_MAR  input  1  load MAR from BUS.
- LD_MDR  input  1  load MDR from BUS (non-memory path).
- MIO_EN  input  1  request memory access.
- R_W  input  1  access direction: 1 = write, 0 = read; sampled with MIO_EN.
- MAR_OUT  output  16  MAR contents.
- MDR_OUT  output  16  MDR contents; feeds bus driver.
- R  output  1  access complete, registered.
- ERR  output  1  sticky timeout flag.
- MEM_ADDR  output  16  memory address, equal to MAR.
- MEM_WDATA  output  16  memory write data, equal to MDR.
- MEM_REQ  output  1  transaction request, registered.
- MEM_WE  output  1  1 = write transaction, registered.
- MEM_RDATA  input  16  read data, valid when MEM_ACK=1.
- MEM_ACK  input  1  memory completion, one-cycle pulse.

Behaviour:
- Reset (i_Rst=1 at an edge), any state including mid-access:
  - state=IDLE; MAR=0, MDR=0, R=0, ERR=0, MEM_REQ=0, MEM_WE=0, counter=0.
  - Any in-flight transaction is abandoned; a late MEM_ACK after reset is ignored.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - LD_MAR=1: MAR<=BUS.
  - LD_MDR=1 and not (MIO_EN=1 and R_W=0): MDR<=BUS.
  - MIO_EN=1, R_W=0: go to READ; MEM_REQ<=1, MEM_WE<=0; counter<=0.
  - MIO_EN=1, R_W=1: go to WRITE; MEM_REQ<=1, MEM_WE<=1; counter<=0.
  - Loads and start happen at the same edge, so the transaction uses the newly loaded MAR/MDR.
- READ/WRITE:
  - MEM_REQ, MEM_WE, MAR and MDR are held stable; LD_MAR and LD_MDR are ignored.
  - MEM_ACK=1 at an edge:
    - READ: MDR<=MEM_RDATA. WRITE: MDR unchanged.
    - MEM_REQ<=0, MEM_WE<=0, R<=1; go to DONE.
  - No ack: counter increments. When counter reaches TIMEOUT_CYCLES-1 without ack:
    - MEM_REQ<=0, MEM_WE<=0, R<=1, ERR<=1; go to DONE.
    - MDR unchanged.
  - An ack arriving on the same edge as timeout wins: normal completion, ERR not set.
- DONE:
  - R=1 for exactly one cycle. Next edge: R<=0, go to IDLE.
  - MIO_EN, LD_MAR and LD_MDR are ignored in DONE. The control FSM drops MIO_EN after sampling R.
- Latency:
  - MEM_REQ high the cycle after MIO_EN is sampled in IDLE.
  - R high the cycle after the MEM_ACK edge.
  - Minimum access, MIO_EN sample to R high: 2 cycles.
- MEM_ACK outside READ/WRITE is ignored.
- ERR clears only on reset.
- MAR_OUT, MEM_ADDR, MDR_OUT and MEM_WDATA are direct register outputs with no combinational path from inputs.

Test Plan:
- Reset mid-read: start read, assert i_Rst before ack.
  - Next cycle: MEM_REQ=0, R=0, MAR=0, MDR=0, state IDLE.
  - A subsequent MEM_ACK with MEM_RDATA=16'hBEEF leaves MDR=0.
- Register loads: BUS=16'h3000 with LD_MAR -> MAR_OUT=16'h3000. BUS=16'h1234 with LD_MDR, MIO_EN=0 -> MDR_OUT=16'h1234 next cycle.
- Read with 3-cycle memory latency: MAR=16'h3000, MIO_EN=1, R_W=0; ack with MEM_RDATA=16'hA5A5 three cycles after MEM_REQ rises.
  - MEM_ADDR=16'h3000, MEM_WE=0 throughout.
  - MDR=16'hA5A5 and R=1 on the cycle after ack; R=0 the cycle after that.
- Write with same-edge loads: LD_MAR (BUS=16'h4000), then LD_MDR, MIO_EN=1, R_W=1 with BUS=16'h00FF in the same cycle.
  - MEM_WDATA=16'h00FF, MEM_WE=1, MEM_ADDR=16'h4000.
  - Ack -> R=1 for one cycle; MDR stays 16'h00FF.
- Timeout: TIMEOUT_CYCLES=4, read with no ack.
  - MEM_REQ drops after 4 cycles in READ; R=1 for one cycle; ERR=1; MDR unchanged.
  - ERR stays 1 through a later successful access until i_Rst.
- Ignored inputs during access: LD_MAR with BUS=16'hFFFF and LD_MDR pulsed while in READ -> MAR and MDR unchanged. MIO_EN held high through DONE -> exactly one transaction.

Source files
------------

// File: rtl/mar_mdr_mem_if.sv
// LC-3 memory-interface stage: MAR/MDR registers plus req/ack memory transactions with timeout abort.
// Latency: MEM_REQ one cycle after MIO_EN in IDLE, R one cycle after MEM_ACK; memory stalls are bounded by TIMEOUT_CYCLES.
module mar_mdr_mem_if #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        i_Clk,
   input  logic        i_Rst,
   input  logic [15:0] BUS,
   input  logic        LD_MAR,
   input  logic        LD_MDR,
   input  logic        MIO_EN,
   input  logic        R_W,
   output logic [15:0] MAR_OUT,
   output logic [15:0] MDR_OUT,
   output logic        R,
   output logic        ERR,
   output logic [15:0] MEM_ADDR,
   output logic [15:0] MEM_WDATA,
   output logic        MEM_REQ,
   output logic        MEM_WE,
   input  logic [15:0] MEM_RDATA,
   input  logic        MEM_ACK
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_nxt;
   logic [15:0]      mar_q, mar_nxt;
   logic [15:0]      mdr_q, mdr_nxt;
   logic             r_q, r_nxt;
   logic             err_q, err_nxt;
   logic             req_q, req_nxt;
   logic             we_q, we_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q <= S_IDLE;
         mar_q   <= '0;
         mdr_q   <= '0;
         r_q     <= 1'b0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nxt;
         mar_q   <= mar_nxt;
         mdr_q   <= mdr_nxt;
         r_q     <= r_nxt;
         err_q   <= err_nxt;
         req_q   <= req_nxt;
         we_q    <= we_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      mar_nxt   = mar_q;
      mdr_nxt   = mdr_q;
      r_nxt     = r_q;
      err_nxt   = err_q;
      req_nxt   = req_q;
      we_nxt    = we_q;
      cnt_nxt   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (LD_MAR) mar_nxt = BUS;
            // A read launched on this edge will overwrite MDR, so a bus load would be meaningless.
            if (LD_MDR && !(MIO_EN && !R_W)) mdr_nxt = BUS;
            if (MIO_EN) begin
               state_nxt = R_W ? S_WRITE : S_READ;
               req_nxt   = 1'b1;
               we_nxt    = R_W;
               cnt_nxt   = '0;
            end
         end
         S_READ, S_WRITE: begin
            if (MEM_ACK) begin
               if (state_q == S_READ) mdr_nxt = MEM_RDATA;
               req_nxt   = 1'b0;
               we_nxt    = 1'b0;
               r_nxt     = 1'b1;
               state_nxt = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               req_nxt   = 1'b0;
               we_nxt    = 1'b0;
               r_nxt     = 1'b1;
               err_nxt   = 1'b1;
               state_nxt = S_DONE;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            r_nxt     = 1'b0;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign MAR_OUT   = mar_q;
   assign MEM_ADDR  = mar_q;
   assign MDR_OUT   = mdr_q;
   assign MEM_WDATA = mdr_q;
   assign R         = r_q;
   assign ERR       = err_q;
   assign MEM_REQ   = req_q;
   assign MEM_WE    = we_q;

endmodule

// File: tb/tb_mar_mdr_mem_if.sv
// Bench for mar_mdr_mem_if: directed test-plan steps followed by randomized transactions
// checked against a transaction-level model (ack latency vs. timeout arithmetic).
module tb_mar_mdr_mem_if;

   localparam int TO = 4;

   logic        i_Clk = 1'b0;
   logic        i_Rst;
   logic [15:0] BUS;
   logic        LD_MAR, LD_MDR, MIO_EN, R_W;
   logic [15:0] MAR_OUT, MDR_OUT, MEM_ADDR, MEM_WDATA, MEM_RDATA;
   logic        R, ERR, MEM_REQ, MEM_WE, MEM_ACK;

   int checks   = 0;
   int failures = 0;

   logic [15:0] m_mar, m_mdr;
   logic        m_err;

   mar_mdr_mem_if #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
      .i_Clk    (i_Clk),
      .i_Rst    (i_Rst),
      .BUS      (BUS),
      .LD_MAR   (LD_MAR),
      .LD_MDR   (LD_MDR),
      .MIO_EN   (MIO_EN),
      .R_W      (R_W),
      .MAR_OUT  (MAR_OUT),
      .MDR_OUT  (MDR_OUT),
      .R        (R),
      .ERR      (ERR),
      .MEM_ADDR (MEM_ADDR),
      .MEM_WDATA(MEM_WDATA),
      .MEM_REQ  (MEM_REQ),
      .MEM_WE   (MEM_WE),
      .MEM_RDATA(MEM_RDATA),
      .MEM_ACK  (MEM_ACK)
   );

   always #5 i_Clk = ~i_Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One full access: load MAR, then start (with MDR load on writes), ack after lat cycles in READ/WRITE.
   task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                         input int lat, input logic [15:0] rdata);
      int n;
      n = (lat < TO) ? lat : TO;
      BUS = addr; LD_MAR = 1'b1;
      tick();
      m_mar = addr;
      LD_MAR = 1'b0;
      BUS = wdata; LD_MDR = 1'b1; MIO_EN = 1'b1; R_W = wr;
      tick();
      if (wr) m_mdr = wdata;
      LD_MDR = 1'b0;
      chk1 ("req_rise",   MEM_REQ,   1'b1);
      chk1 ("we_start",   MEM_WE,    wr);
      chk16("addr_start", MEM_ADDR,  m_mar);
      chk16("wdata",      MEM_WDATA, m_mdr);
      for (int k = 1; k <= n; k++) begin
         BUS = 16'($urandom); LD_MAR = 1'b1; LD_MDR = 1'b1;
         MEM_ACK   = (k == lat);
         MEM_RDATA = (k == lat) ? rdata : 16'($urandom);
         tick();
         if (k < n) begin
            chk1 ("req_hold",  MEM_REQ,  1'b1);
            chk1 ("r_busy",    R,        1'b0);
            chk1 ("we_hold",   MEM_WE,   wr);
            chk16("addr_hold", MEM_ADDR, m_mar);
            chk16("mdr_hold",  MDR_OUT,  m_mdr);
         end
      end
      MEM_ACK = 1'b0;
      if (lat <= TO) begin
         if (!wr) m_mdr = rdata;
      end else begin
         m_err = 1'b1;
      end
      chk1 ("r_done",   R,       1'b1);
      chk1 ("req_drop", MEM_REQ, 1'b0);
      chk1 ("we_drop",  MEM_WE,  1'b0);
      chk16("mdr_done", MDR_OUT, m_mdr);
      chk16("mar_done", MAR_OUT, m_mar);
      chk1 ("err_done", ERR,     m_err);
      tick();
      chk1 ("r_pulse_end", R,       1'b0);
      chk1 ("no_retrig",   MEM_REQ, 1'b0);
      chk16("mar_ignored", MAR_OUT, m_mar);
      chk16("mdr_ignored", MDR_OUT, m_mdr);
      MIO_EN = 1'b0; LD_MAR = 1'b0; LD_MDR = 1'b0; R_W = 1'b0;
      tick();
      chk1 ("one_txn",  MEM_REQ, 1'b0);
      chk1 ("err_keep", ERR,     m_err);
   endtask

   initial begin
      i_Rst = 1'b1; BUS = '0; LD_MAR = 1'b0; LD_MDR = 1'b0; MIO_EN = 1'b0; R_W = 1'b0;
      MEM_RDATA = '0; MEM_ACK = 1'b0;
      m_mar = '0; m_mdr = '0; m_err = 1'b0;
      tick();
      tick();
      chk16("rst_mar", MAR_OUT, 16'h0000);
      chk16("rst_mdr", MDR_OUT, 16'h0000);
      chk1 ("rst_r",   R,       1'b0);
      chk1 ("rst_err", ERR,     1'b0);
      chk1 ("rst_req", MEM_REQ, 1'b0);
      chk1 ("rst_we",  MEM_WE,  1'b0);
      i_Rst = 1'b0;

      // Plain register loads
      BUS = 16'h3000; LD_MAR = 1'b1;
      tick();
      LD_MAR = 1'b0; m_mar = 16'h3000;
      chk16("ld_mar", MAR_OUT, 16'h3000);
      BUS = 16'h1234; LD_MDR = 1'b1;
      tick();
      LD_MDR = 1'b0; m_mdr = 16'h1234;
      chk16("ld_mdr", MDR_OUT, 16'h1234);

      // Directed accesses: 3-cycle read, same-edge write, timeout, then a good access with ERR sticky
      do_txn(1'b0, 16'h3000, 16'h5555, 3, 16'hA5A5);
      chk16("read_a5a5", MDR_OUT, 16'hA5A5);
      do_txn(1'b1, 16'h4000, 16'h00FF, 2, 16'hDEAD);
      chk16("write_mdr", MDR_OUT, 16'h00FF);
      do_txn(1'b0, 16'h5000, 16'h7777, TO + 5, 16'h0000);
      chk1("timeout_err", ERR, 1'b1);
      do_txn(1'b0, 16'h6000, 16'h0000, TO, 16'h1357);
      chk1("err_sticky", ERR, 1'b1);

      // Ack outside an access is ignored
      MEM_ACK = 1'b1; MEM_RDATA = 16'hBEEF;
      tick();
      MEM_ACK = 1'b0;
      chk16("idle_ack_mdr", MDR_OUT, m_mdr);
      chk1 ("idle_ack_r",   R,       1'b0);

      for (int t = 0; t < 24; t++) begin
         do_txn(1'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(1, TO + 2)),
                16'($urandom));
      end

      // Reset in the middle of a read; a late ack must not land
      BUS = 16'h3000; LD_MAR = 1'b1;
      tick();
      LD_MAR = 1'b0; MIO_EN = 1'b1; R_W = 1'b0;
      tick();
      MIO_EN = 1'b0;
      tick();
      i_Rst = 1'b1;
      tick();
      i_Rst = 1'b0;
      chk1 ("mid_rst_req", MEM_REQ, 1'b0);
      chk1 ("mid_rst_r",   R,       1'b0);
      chk16("mid_rst_mar", MAR_OUT, 16'h0000);
      chk16("mid_rst_mdr", MDR_OUT, 16'h0000);
      chk1 ("mid_rst_err", ERR,     1'b0);
      MEM_ACK = 1'b1; MEM_RDATA = 16'hBEEF;
      tick();
      MEM_ACK = 1'b0;
      chk16("late_ack_mdr", MDR_OUT, 16'h0000);
      chk1 ("late_ack_r",   R,       1'b0);
      chk1 ("late_ack_req", MEM_REQ, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
